// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants, capture FSM encoding and framebuffer write record.
// The VGA framebuffer reader imports the same constants so both sides agree on the layout.
package gb_video_pkg;

  localparam int GB_H_PIX     = 160;
  localparam int GB_V_LINES   = 144;
  localparam int GB_FB_DEPTH  = GB_H_PIX * GB_V_LINES;
  localparam int GB_FB_AW     = 15;
  localparam int GB_PIX_W     = 2;

  typedef logic [GB_FB_AW-1:0] fb_addr_t;
  typedef logic [GB_PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_WAIT_HS = 2'd1,
    S_LINE    = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic     en;
    fb_addr_t addr;
    pix_t     data;
  } fb_wr_t;

endpackage

// File: rtl/gb_lcd_capture_if.sv
// LCD pin bundle plus framebuffer write / status outputs of the capture block.
// master = LCD source and framebuffer/control consumer, slave = capture block.
interface gb_lcd_capture_if;
  import gb_video_pkg::*;

  logic       lcd_clk;
  logic       lcd_hsync;
  logic       lcd_vsync;
  pix_t       lcd_data;
  logic       fb_wr_en;
  fb_addr_t   fb_wr_addr;
  pix_t       fb_wr_data;
  logic       frame_done;
  logic       sync_error;
  logic [7:0] frame_count;

  modport master (
    output lcd_clk, lcd_hsync, lcd_vsync, lcd_data,
    input  fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, sync_error, frame_count
  );

  modport slave (
    input  lcd_clk, lcd_hsync, lcd_vsync, lcd_data,
    output fb_wr_en, fb_wr_addr, fb_wr_data, frame_done, sync_error, frame_count
  );

endinterface

// File: rtl/gb_sync_edge.sv
// N-stage synchronizer for one async input, with registered rise/fall pulses.
// Edge pulses appear STAGES+1 clk after the pin changes.
module gb_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~hist_q;
    fall_d = ~sync_q[STAGES-1] & hist_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the async Game Boy LCD bus and writes each frame row-major into the 2-bit framebuffer.
// Pin-to-write latency SYNC_STAGES+2 clk; no backpressure, one write per pixel clock fall.
module gb_lcd_capture
  import gb_video_pkg::*;
#(
  parameter int H_PIX       = GB_H_PIX,
  parameter int V_LINES     = GB_V_LINES,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  gb_lcd_capture_if.slave  bus
);

  localparam int PX_W = $clog2(H_PIX + 1);
  localparam int LN_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  logic pix_fall, hs_rise, vs_rise;
  logic pix_rise_unused, hs_fall_unused, vs_fall_unused;

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(clk), .reset(reset), .din(bus.lcd_clk),
    .rise(pix_rise_unused), .fall(pix_fall)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk(clk), .reset(reset), .din(bus.lcd_hsync),
    .rise(hs_rise), .fall(hs_fall_unused)
  );

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vs (
    .clk(clk), .reset(reset), .din(bus.lcd_vsync),
    .rise(vs_rise), .fall(vs_fall_unused)
  );

  // One stage deeper than the sync chain because the edge pulses are registered.
  logic [SYNC_STAGES:0][GB_PIX_W-1:0] data_q, data_d;
  pix_t                               pix_sample;

  always_comb begin
    data_d     = {data_q[SYNC_STAGES-1:0], bus.lcd_data};
    pix_sample = data_q[SYNC_STAGES];
  end

  cap_state_e      state_q, state_d;
  logic [PX_W-1:0] px_q, px_d;
  logic [LN_W-1:0] ln_q, ln_d;
  fb_addr_t        addr_q, addr_d;
  fb_wr_t          wr_q, wr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      fc_q, fc_d;
  logic            partial;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    ln_d    = ln_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fc_d    = fc_q;
    partial = (ln_q != '0) || (px_q != '0);

    // vsync wins over everything; a same-cycle hsync opens line 0 directly.
    if (vs_rise) begin
      err_d   = (state_q != S_WAIT_VS) && partial;
      ln_d    = '0;
      px_d    = '0;
      addr_d  = '0;
      state_d = hs_rise ? S_LINE : S_WAIT_HS;
    end else begin
      case (state_q)
        S_WAIT_VS: ;
        S_WAIT_HS: begin
          if (hs_rise) begin
            px_d    = '0;
            state_d = S_LINE;
          end
        end
        S_LINE: begin
          if (hs_rise) begin
            err_d   = 1'b1;
            state_d = S_WAIT_VS;
          end else if (pix_fall) begin
            wr_d.en   = 1'b1;
            wr_d.addr = addr_q;
            wr_d.data = pix_sample;
            addr_d    = addr_q + GB_FB_AW'(1);
            px_d      = px_q + PX_W'(1);
            if (px_q == PX_W'(H_PIX - 1)) begin
              if (ln_q == LN_W'(V_LINES - 1)) begin
                done_d  = 1'b1;
                fc_d    = fc_q + 8'd1;
                state_d = S_WAIT_VS;
              end else begin
                ln_d    = ln_q + LN_W'(1);
                state_d = S_WAIT_HS;
              end
            end
          end
        end
        default: state_d = S_WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      state_q <= S_WAIT_VS;
      px_q    <= '0;
      ln_q    <= '0;
      addr_q  <= '0;
      wr_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      data_q  <= data_d;
      state_q <= state_d;
      px_q    <= px_d;
      ln_q    <= ln_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.fb_wr_en    = wr_q.en;
  assign bus.fb_wr_addr  = wr_q.addr;
  assign bus.fb_wr_data  = wr_q.data;
  assign bus.frame_done  = done_q;
  assign bus.sync_error  = err_q;
  assign bus.frame_count = fc_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Directed bench for gb_lcd_capture on a reduced 16x6 geometry so whole frames fit a short run.
module tb_gb_lcd_capture;

  localparam int H     = 16;
  localparam int V     = 6;
  localparam int SS    = 2;
  localparam int DEPTH = H * V;

  logic clk;
  logic reset;

  gb_lcd_capture_if bus();

  gb_lcd_capture #(.H_PIX(H), .V_LINES(V), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  data;
  } wexp_t;

  wexp_t exp_q[$];

  typedef enum int {OP_PIXRUN, OP_VSHS, OP_VS, OP_HS, OP_PIXLINE, OP_HSLINE, OP_FRAME} op_e;

  typedef struct {
    op_e op;
    int  n;
    int  base;
    int  d_wr;
    int  d_done;
    int  d_err;
    int  fc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (bus.fb_wr_en) begin
      wr_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %0d data %0d, expected no write",
                 bus.fb_wr_addr, bus.fb_wr_data);
      end else begin
        wexp_t e;
        e = exp_q.pop_front();
        if (bus.fb_wr_addr != e.addr || bus.fb_wr_data != e.data) begin
          n_fail++;
          $display("FAIL wr_match: got addr %0d data %0d, expected addr %0d data %0d",
                   bus.fb_wr_addr, bus.fb_wr_data, e.addr, e.data);
        end
      end
    end
    if (bus.frame_done) done_cnt++;
    if (bus.sync_error) err_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input logic [1:0] d);
    bus.lcd_data = d;
    bus.lcd_clk  = 1'b1;
    step(2);
    bus.lcd_clk  = 1'b0;
    step(2);
  endtask

  task automatic line(input int n);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      d = i[1:0];
      pix(d);
    end
  endtask

  task automatic hs_pulse();
    bus.lcd_hsync = 1'b1;
    step(2);
    bus.lcd_hsync = 1'b0;
    step(2);
  endtask

  task automatic vs_only();
    bus.lcd_vsync = 1'b1;
    step(2);
    bus.lcd_vsync = 1'b0;
    step(2);
  endtask

  task automatic vs_hs();
    bus.lcd_vsync = 1'b1;
    bus.lcd_hsync = 1'b1;
    step(2);
    bus.lcd_vsync = 1'b0;
    bus.lcd_hsync = 1'b0;
    step(2);
  endtask

  task automatic frame();
    vs_hs();
    line(H);
    for (int l = 1; l < V; l++) begin
      hs_pulse();
      line(H);
    end
  endtask

  // Pixel falling edge landing in the same cycle as an hsync rising edge.
  task automatic pix_with_hs(input logic [1:0] d);
    bus.lcd_data  = d;
    bus.lcd_clk   = 1'b1;
    step(2);
    bus.lcd_clk   = 1'b0;
    bus.lcd_hsync = 1'b1;
    step(2);
    bus.lcd_hsync = 1'b0;
    step(2);
  endtask

  task automatic push_exp(input int base, input int n);
    wexp_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = 15'(base + k);
      e.data = e.addr[1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic add(input op_e op, input int n, input int base, input int wr,
                     input int dn, input int er, input int fc);
    vec_t v;
    v.op = op; v.n = n; v.base = base; v.d_wr = wr;
    v.d_done = dn; v.d_err = er; v.fc = fc;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"},  int'(bus.fb_wr_en),    0);
    chk({tag, "_addr"},   int'(bus.fb_wr_addr),  0);
    chk({tag, "_data"},   int'(bus.fb_wr_data),  0);
    chk({tag, "_done"},   int'(bus.frame_done),  0);
    chk({tag, "_err"},    int'(bus.sync_error),  0);
    chk({tag, "_fcount"}, int'(bus.frame_count), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0, e0, lat;

    reset         = 1'b1;
    bus.lcd_clk   = 1'b0;
    bus.lcd_hsync = 1'b0;
    bus.lcd_vsync = 1'b0;
    bus.lcd_data  = 2'd0;
    #23;
    chk_outputs_zero("reset");
    step(1);
    reset = 1'b0;
    step(2);

    // Pin-to-write latency for a single pixel at the start of line 0.
    vs_hs();
    push_exp(0, 1);
    bus.lcd_data = 2'd0;
    bus.lcd_clk  = 1'b1;
    step(2);
    bus.lcd_clk  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.fb_wr_en) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, SS + 2);
    step(4);
    exp_q.delete();
    do_reset();

    add(OP_PIXRUN,  20, 0,  0,  0, 0, 0);   // pixel clocks before any vsync
    add(OP_VSHS,     0, 0,  0,  0, 0, 0);
    add(OP_PIXLINE, 16, 0,  16, 0, 0, 0);
    add(OP_HSLINE,  16, 16, 16, 0, 0, 0);
    add(OP_HSLINE,  16, 32, 16, 0, 0, 0);
    add(OP_HSLINE,  16, 48, 16, 0, 0, 0);
    add(OP_HSLINE,  16, 64, 16, 0, 0, 0);
    add(OP_HSLINE,  16, 80, 16, 1, 0, 1);
    add(OP_PIXRUN,   8, 0,  0,  0, 0, 1);
    add(OP_FRAME,    0, 0,  DEPTH, 1, 0, 2);
    add(OP_VSHS,     0, 0,  0,  0, 0, 2);   // short line 3
    add(OP_PIXLINE, 16, 0,  16, 0, 0, 2);
    add(OP_HSLINE,  16, 16, 16, 0, 0, 2);
    add(OP_HSLINE,  16, 32, 16, 0, 0, 2);
    add(OP_HSLINE,  10, 48, 10, 0, 0, 2);
    add(OP_HS,       0, 0,  0,  0, 1, 2);
    add(OP_PIXRUN,  20, 0,  0,  0, 0, 2);
    add(OP_HSLINE,  16, 0,  0,  0, 0, 2);
    add(OP_FRAME,    0, 0,  DEPTH, 1, 0, 3);
    add(OP_VSHS,     0, 0,  0,  0, 0, 3);   // vsync at line 4 pixel 5
    add(OP_PIXLINE, 16, 0,  16, 0, 0, 3);
    add(OP_HSLINE,  16, 16, 16, 0, 0, 3);
    add(OP_HSLINE,  16, 32, 16, 0, 0, 3);
    add(OP_HSLINE,  16, 48, 16, 0, 0, 3);
    add(OP_HSLINE,   5, 64, 5,  0, 0, 3);
    add(OP_FRAME,    0, 0,  DEPTH, 1, 1, 4);
    add(OP_VSHS,     0, 0,  0,  0, 0, 4);   // bare vsync while waiting for hsync
    add(OP_PIXLINE, 16, 0,  16, 0, 0, 4);
    add(OP_VS,       0, 0,  0,  0, 1, 4);
    add(OP_VS,       0, 0,  0,  0, 0, 4);
    add(OP_HSLINE,  16, 0,  16, 0, 0, 4);
    add(OP_HSLINE,  16, 16, 16, 0, 0, 4);
    add(OP_HSLINE,  16, 32, 16, 0, 0, 4);
    add(OP_HSLINE,  16, 48, 16, 0, 0, 4);
    add(OP_HSLINE,  16, 64, 16, 0, 0, 4);
    add(OP_HSLINE,  16, 80, 16, 1, 0, 5);

    for (int r = 0; r < tbl.size(); r++) begin
      w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
      push_exp(tbl[r].base, tbl[r].d_wr);
      case (tbl[r].op)
        OP_PIXRUN:  line(tbl[r].n);
        OP_VSHS:    vs_hs();
        OP_VS:      vs_only();
        OP_HS:      hs_pulse();
        OP_PIXLINE: line(tbl[r].n);
        OP_HSLINE:  begin hs_pulse(); line(tbl[r].n); end
        OP_FRAME:   frame();
        default:    ;
      endcase
      step(8);
      chk($sformatf("v%0d_writes", r), wr_cnt - w0, tbl[r].d_wr);
      chk($sformatf("v%0d_done", r), done_cnt - d0, tbl[r].d_done);
      chk($sformatf("v%0d_err", r), err_cnt - e0, tbl[r].d_err);
      chk($sformatf("v%0d_fcount", r), int'(bus.frame_count), tbl[r].fc);
      exp_q.delete();
    end

    // Pixel fall coinciding with hsync: dropped when opening a line, and a short-line error mid-line.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    vs_hs();
    push_exp(0, H);
    line(H);
    pix_with_hs(2'd3);
    push_exp(16, H);
    line(H);
    hs_pulse();
    push_exp(32, 3);
    line(3);
    pix_with_hs(2'd3);
    step(8);
    chk("coinc_writes", wr_cnt - w0, 35);
    chk("coinc_err", err_cnt - e0, 1);
    chk("coinc_done", done_cnt - d0, 0);
    chk("coinc_fcount", int'(bus.frame_count), 5);
    exp_q.delete();

    // Reset in the middle of line 3, then recovery only through a fresh vsync.
    vs_hs();
    push_exp(0, 3 * H + 5);
    line(H);
    hs_pulse(); line(H);
    hs_pulse(); line(H);
    hs_pulse(); line(5);
    step(8);
    chk("pre_reset_addr", int'(bus.fb_wr_addr), 52);
    exp_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_outputs_zero("midreset");
    step(2);
    reset = 1'b0;
    step(2);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    line(10);
    hs_pulse();
    line(H);
    step(8);
    chk("post_reset_writes", wr_cnt - w0, 0);
    chk("post_reset_fcount", int'(bus.frame_count), 0);
    push_exp(0, DEPTH);
    frame();
    step(8);
    chk("recover_writes", wr_cnt - w0, DEPTH);
    chk("recover_done", done_cnt - d0, 1);
    chk("recover_err", err_cnt - e0, 0);
    chk("recover_fcount", int'(bus.frame_count), 1);
    chk("recover_last_addr", int'(bus.fb_wr_addr), DEPTH - 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
